// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gate controller: per-channel req/ack handshake with a
// programmable idle hold-off before each gated clock is stopped.
module clk_gate_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDLE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_an_i,
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] ack_o,
  input  logic [IDLE_W-1:0] idle_cycles_i,
  input  logic              force_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic              active_o
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [IDLE_W-1:0] CNT_ONE = IDLE_W'(1);

  logic [NUM_CH-1:0][1:0]        state_q, state_d;
  logic [NUM_CH-1:0][IDLE_W-1:0] cnt_q,   cnt_d;
  logic [NUM_CH-1:0]             en_q,    en_d;
  logic [NUM_CH-1:0]             ack_q,   ack_d;
  logic                          active_q, active_d;

  logic [NUM_CH-1:0] gate_en_c;
  logic [NUM_CH-1:0] gate_lat;

  // Control registers; reset clears enables asynchronously.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q  <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      ack_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      active_q <= active_d;
    end
  end

  // Per-channel OFF/ON/HOLD handshake and hold-off countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ack_d   = ack_q;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      case (state_q[ch])
        ST_OFF: begin
          if (req_i[ch]) begin
            state_d[ch] = ST_ON;
            en_d[ch]    = 1'b1;
          end
        end
        ST_ON: begin
          ack_d[ch] = 1'b1;
          if (!req_i[ch]) begin
            if (idle_cycles_i == '0) begin
              state_d[ch] = ST_OFF;
              en_d[ch]    = 1'b0;
              ack_d[ch]   = 1'b0;
            end else begin
              state_d[ch] = ST_HOLD;
              cnt_d[ch]   = idle_cycles_i;
            end
          end
        end
        ST_HOLD: begin
          if (req_i[ch]) begin
            state_d[ch] = ST_ON;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_ONE) begin
            state_d[ch] = ST_OFF;
            cnt_d[ch]   = '0;
            en_d[ch]    = 1'b0;
            ack_d[ch]   = 1'b0;
          end else begin
            cnt_d[ch] = cnt_q[ch] - CNT_ONE;
          end
        end
        default: begin
          state_d[ch] = ST_OFF;
          cnt_d[ch]   = '0;
          en_d[ch]    = 1'b0;
          ack_d[ch]   = 1'b0;
        end
      endcase
    end
  end

  // Registered copy of the enable OR, tracking en_q cycle for cycle.
  assign active_d = |en_d;

  // Enable latch is transparent only while clk_i is low, so the gate
  // can never truncate a high phase already in progress.
  assign gate_en_c = en_q | {NUM_CH{force_i}};

  always_latch begin
    if (!clk_i) begin
      gate_lat <= gate_en_c;
    end
  end

  assign clk_o    = {NUM_CH{clk_i}} & gate_lat;
  assign ack_o    = ack_q;
  assign active_o = active_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl (8 channels, 3-bit hold-off): directed handshake,
// hold-off, reset and force scenarios, then random requests vs a timeline model.
module tb_clk_gate_ctrl;

  localparam int unsigned NCH = 8;
  localparam int unsigned IW  = 3;

  logic           clk_i;
  logic           rst_an_i;
  logic [NCH-1:0] req_i;
  logic [NCH-1:0] ack_o;
  logic [IW-1:0]  idle_cycles_i;
  logic           force_i;
  logic [NCH-1:0] clk_o;
  logic           active_o;

  clk_gate_ctrl #(.NUM_CH(NCH), .IDLE_W(IW)) dut (
    .clk_i         (clk_i),
    .rst_an_i      (rst_an_i),
    .req_i         (req_i),
    .ack_o         (ack_o),
    .idle_cycles_i (idle_cycles_i),
    .force_i       (force_i),
    .clk_o         (clk_o),
    .active_o      (active_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observed gated edges and pulse widths per channel.
  int  act_cnt [NCH];
  time rise_t  [NCH];
  time fall_t  [NCH];
  bit  fall_seen [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_mon
    initial begin
      act_cnt[gi]   = 0;
      rise_t[gi]    = 0;
      fall_t[gi]    = 0;
      fall_seen[gi] = 1'b0;
    end
    always @(posedge clk_o[gi]) begin
      act_cnt[gi] = act_cnt[gi] + 1;
      if (fall_seen[gi]) chk($sformatf("low_pulse_ch%0d", gi), 64'($time - fall_t[gi] >= 5), 64'(1));
      rise_t[gi] = $time;
    end
    always @(negedge clk_o[gi]) begin
      chk($sformatf("high_pulse_ch%0d", gi), 64'($time - rise_t[gi] >= 5), 64'(1));
      fall_t[gi]    = $time;
      fall_seen[gi] = 1'b1;
    end
  end

  // Timeline model: a channel is enabled after edge k if its request was
  // sampled high at k, or k is still before (drop edge + hold-off).
  logic [NCH-1:0] m_en, m_ack, m_prev;
  int             hold_until [NCH];
  int             exp_cnt    [NCH];
  int             k;

  task automatic step();
    logic [NCH-1:0] old_en;
    @(posedge clk_i);
    k++;
    for (int c = 0; c < NCH; c++) exp_cnt[c] += (m_en[c] | force_i) ? 1 : 0;
    old_en = m_en;
    if (!rst_an_i) begin
      m_en = '0; m_ack = '0; m_prev = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (req_i[c]) begin
          m_en[c] = 1'b1;
        end else if (m_prev[c]) begin
          hold_until[c] = k + int'(idle_cycles_i);
          m_en[c] = (k < hold_until[c]);
        end else begin
          m_en[c] = (k < hold_until[c]);
        end
        m_prev[c] = req_i[c];
      end
      m_ack = m_en & old_en;
    end
    #1;
    chk("ack", 64'(ack_o), 64'(m_ack));
    chk("active", 64'(active_o), 64'(|m_en));
    for (int c = 0; c < NCH; c++) chk($sformatf("edges_ch%0d", c), 64'(act_cnt[c]), 64'(exp_cnt[c]));
  endtask

  initial begin
    rst_an_i = 1'b0; req_i = '0; idle_cycles_i = '0; force_i = 1'b0;
    m_en = '0; m_ack = '0; m_prev = '0; k = 0;
    for (int c = 0; c < NCH; c++) begin hold_until[c] = 0; exp_cnt[c] = 0; end

    // Reset and idle: everything flat.
    step(); step();
    chk("rst_ack", 64'(ack_o), 64'(0));
    chk("rst_active", 64'(active_o), 64'(0));
    rst_an_i = 1'b1;
    repeat (3) begin step(); chk("idle_clk", 64'(clk_o), 64'(0)); end

    // Force runs every clock, ack untouched.
    force_i = 1'b1;
    step(); chk("force_clk", 64'(clk_o), 64'(8'hFF)); chk("force_ack", 64'(ack_o), 64'(0));
    repeat (3) step();
    force_i = 1'b0;
    step(); chk("unforce_clk", 64'(clk_o), 64'(0));

    // Ch0 turn-on: active after k, first gated edge k+1, ack after k+1.
    req_i[0] = 1'b1;
    step();
    chk("on_active", 64'(active_o), 64'(1));
    chk("on_ack_early", 64'(ack_o[0]), 64'(0));
    chk("on_clk_early", 64'(clk_o[0]), 64'(0));
    step();
    chk("on_clk0", 64'(clk_o[0]), 64'(1));
    chk("on_ack0", 64'(ack_o[0]), 64'(1));
    chk("on_others", 64'(clk_o[7:1]), 64'(0));

    // Ch1 hold-off of 5: gated edges through k+5, ack falls after k+5.
    idle_cycles_i = 3'd5;
    req_i[1] = 1'b1;
    step(); step();
    req_i[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("hold_clk1_%0d", i), 64'(clk_o[1]), 64'(1));
      chk($sformatf("hold_ack1_%0d", i), 64'(ack_o[1]), 64'(i < 5));
    end
    step(); chk("hold_clk1_end", 64'(clk_o[1]), 64'(0));

    // Ch1 zero hold-off: ack falls right after the drop edge.
    idle_cycles_i = 3'd0;
    req_i[1] = 1'b1;
    step(); step();
    req_i[1] = 1'b0;
    step();
    chk("zero_ack1", 64'(ack_o[1]), 64'(0));
    chk("zero_clk1_last", 64'(clk_o[1]), 64'(1));
    step(); chk("zero_clk1_off", 64'(clk_o[1]), 64'(0));

    // Ch2 re-raise during hold: no ack dip, no clock gap; later drop reloads.
    idle_cycles_i = 3'd5;
    req_i[2] = 1'b1;
    step(); step();
    req_i[2] = 1'b0;
    repeat (3) begin step(); chk("rr_ack2", 64'(ack_o[2]), 64'(1)); chk("rr_clk2", 64'(clk_o[2]), 64'(1)); end
    req_i[2] = 1'b1;
    repeat (7) begin step(); chk("rr_ack2_on", 64'(ack_o[2]), 64'(1)); chk("rr_clk2_on", 64'(clk_o[2]), 64'(1)); end
    req_i[2] = 1'b0;
    idle_cycles_i = 3'd5;
    for (int i = 0; i < 6; i++) begin step(); chk("rr_tail_clk2", 64'(clk_o[2]), 64'(1)); end
    step(); chk("rr_off_clk2", 64'(clk_o[2]), 64'(0)); chk("rr_off_ack2", 64'(ack_o[2]), 64'(0));

    // Reset while all channels run and clk_i is high.
    idle_cycles_i = 3'd0;
    req_i = 8'hFF;
    repeat (3) step();
    #1;
    rst_an_i = 1'b0;
    m_en = '0; m_ack = '0; m_prev = '0;
    #1;
    chk("mid_rst_ack", 64'(ack_o), 64'(0));
    chk("mid_rst_clk_high", 64'(clk_o), 64'(8'hFF));
    @(negedge clk_i); #1;
    chk("mid_rst_clk_low", 64'(clk_o), 64'(0));
    req_i = '0;
    step(); step();
    chk("mid_rst_clk_flat", 64'(clk_o), 64'(0));
    rst_an_i = 1'b1;
    step();

    // Random requests, hold-off values and force windows.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 7) == 0) req_i[c] = ~req_i[c];
      if ($urandom_range(0, 31) == 0) idle_cycles_i = IW'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) force_i = ~force_i;
      step();
    end
    force_i = 1'b0;
    req_i = '0;
    repeat (10) step();
    chk("final_idle_clk", 64'(clk_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
